conv_result_streamer: RTL
=========================

# conv_result_streamer

Serializes the packed result matrix of the convolution unit into a stream of one 8-bit element per beat. Elements are emitted in row-major order with a valid/ready handshake, so downstream consumers (display driver, UART TX formatter) can take one element at a time. On `start`, the block latches the matrix and its dimensions. It then walks rows and columns and flags the final element.

## Interface
- `MAX_DIM`, 5, maximum rows/columns of the packed matrix
- `ELEM_WIDTH`, 8, bits per element
- `clk` in 1 — sole clock, rising edge
- `reset` in 1 — synchronous, active-low
- `start` in 1 — capture request, sampled in IDLE only
- `src_valid` in 1 — convolution result valid
- `src_m` in 3 — result rows
- `src_n` in 3 — result columns
- `src_matrix` in MAX_DIM*MAX_DIM*ELEM_WIDTH (200) — packed result; element (r,c) at bits [(r*MAX_DIM+c)*ELEM_WIDTH +: ELEM_WIDTH]
- `busy` out 1 — high in STREAM and DONE
- `err` out 1 — one-cycle pulse on rejected start
- `out_valid` out 1 — element available
- `out_ready` in 1 — consumer accepts
- `out_data` out ELEM_WIDTH — current element
- `out_row` out 3 — row index of current element
- `out_col` out 3 — column index of current element
- `out_last` out 1 — current element is (m-1, n-1)
- `done` out 1 — one-cycle pulse after last beat accepted
- `beat_count` out 5 — accepted beats since last start

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE, start=1:
  - The start is accepted when src_valid=1, 1≤src_m≤MAX_DIM and 1≤src_n≤MAX_DIM.
  - On acceptance: latch src_matrix/src_m/src_n into shadow registers, set row=col=0, clear beat_count, go to STREAM.
  - Otherwise: pulse err for one cycle and stay in IDLE.
- STREAM:
  - out_valid=1; out_data is the shadow element (row,col); out_last=(row==m-1 && col==n-1).
  - A beat is the cycle in which out_valid && out_ready; each beat increments beat_count.
  - On a beat with out_last: go to DONE.
  - On a beat with col==n-1 (not last): col=0, row+1.
  - On any other beat: col+1.
  - Without out_ready, all outputs hold stable; no change is permitted while stalled.
- DONE: done=1 for exactly one cycle, then go to IDLE. beat_count holds until the next accepted start.
- start in STREAM or DONE is ignored and raises no err.
- Source inputs may change after capture without affecting the stream.
- Index arithmetic is unsigned 3-bit. Shadow index = row*MAX_DIM+col (0..24). Element select is a 25:1 mux.

## Timing
- All outputs are registered.
- Reset (reset=0 at a rising edge) forces IDLE and sets busy, err, out_valid, out_data, out_row, out_col, out_last, done and beat_count all to 0. Shadow registers are also cleared.
- Reset mid-stream abandons the transfer immediately; out_valid is 0 from the next cycle.
- Start accepted at edge k: out_valid=1 with element (0,0) from edge k through at least the next edge.
- With out_ready held high, the block sustains one element per cycle. An m×n result takes m·n cycles in STREAM plus 1 cycle in DONE.
- Minimum gap between done and the next accepted start is 1 cycle, since the block returns to IDLE after DONE.
- err is asserted in the cycle after the rejected start edge.

## Structure
- Shared package `conv_pkg`:
  - MAX_DIM, ELEM_WIDTH, MAT_W (=MAX_DIM*MAX_DIM*ELEM_WIDTH)
  - the streamer state enum
  - a function computing the element bit offset (r*MAX_DIM+c)*ELEM_WIDTH, shared with the convolution unit
- One sub-module, `rc_index_counter`: row/column counter with enable, runtime limits m/n, wrap and last flag.

## Test plan
- 5×5 input with all-ones 3×3 kernel gives a 3×3 result of 9s; start with out_ready=1 → 9 consecutive beats of 0x09, indices (0,0)…(2,2), out_last on beat 9, done one cycle later, beat_count=9.
- 2×3 result with elements 1..6 and out_ready toggling 1,0,0,1,… → data sequence 1,2,3,4,5,6, outputs stable across stalls, row wraps after col=2.
- 1×1 result of 0xAB → single beat with out_last=1 on the first STREAM cycle, then done; busy is high for 2 cycles.
- start with src_valid=0 (or src_m=0, or src_n=6) → err pulses for 1 cycle, busy stays 0, out_valid stays 0.
- Assert reset=0 after beat 4 of a 9-element stream → next cycle all outputs are 0 and state is IDLE; a new start then replays from (0,0).
- Pulse start and change src_matrix during STREAM → start is ignored and the stream shows the originally captured values.

Source files
------------

// File: rtl/conv_result_streamer_pkg.sv
// Shared definitions for the convolution result path: matrix geometry,
// streamer state encoding and the packed-element offset helper.
package conv_pkg;

  localparam int unsigned MAX_DIM    = 5;
  localparam int unsigned ELEM_WIDTH = 8;
  localparam int unsigned MAT_W      = MAX_DIM * MAX_DIM * ELEM_WIDTH;

  // Dimension limit in the 3-bit width used by the row/column indices.
  localparam logic [2:0]  DIM_MAX_U3 = 3'(MAX_DIM);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } stream_state_t;

  // Bit offset of element (r,c) inside the packed row-major matrix.
  function automatic int unsigned elem_offset(input int unsigned r,
                                              input int unsigned c);
    return (r * MAX_DIM + c) * ELEM_WIDTH;
  endfunction

endpackage

// File: rtl/conv_result_streamer_if.sv
// Element stream between the result streamer and its consumer.
interface conv_result_streamer_if;
  import conv_pkg::*;

  logic                  out_valid;
  logic                  out_ready;
  logic [ELEM_WIDTH-1:0] out_data;
  logic [2:0]            out_row;
  logic [2:0]            out_col;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/rc_index_counter.sv
// Row-major row/column walker with runtime limits. Row, column and the
// last-element flag are all registered; the next position is exported
// combinationally so the owner can prefetch the matching element.
module rc_index_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic [2:0] i_m,
  input  logic [2:0] i_n,
  output logic [2:0] o_row,
  output logic [2:0] o_col,
  output logic       o_last,
  output logic       o_wrap,
  output logic [2:0] o_nxt_row,
  output logic [2:0] o_nxt_col
);

  logic [2:0] r_row;
  logic [2:0] r_col;
  logic       r_last;
  logic       w_col_end;
  logic [2:0] w_nxt_row;
  logic [2:0] w_nxt_col;
  logic       w_nxt_last;

  // Next position: column wraps to 0 and row advances at the end of a row.
  always_comb begin
    w_col_end  = (r_col == (i_n - 3'd1));
    w_nxt_col  = w_col_end ? 3'd0 : (r_col + 3'd1);
    w_nxt_row  = w_col_end ? (r_row + 3'd1) : r_row;
    w_nxt_last = (w_nxt_row == (i_m - 3'd1)) && (w_nxt_col == (i_n - 3'd1));
  end

  // Position registers: clear restarts at (0,0), enable steps one element.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_row  <= 3'd0;
      r_col  <= 3'd0;
      r_last <= 1'b0;
    end else if (i_clear) begin
      r_row  <= 3'd0;
      r_col  <= 3'd0;
      r_last <= (i_m == 3'd1) && (i_n == 3'd1);
    end else if (i_en) begin
      r_row  <= w_nxt_row;
      r_col  <= w_nxt_col;
      r_last <= w_nxt_last;
    end
  end

  assign o_row     = r_row;
  assign o_col     = r_col;
  assign o_last    = r_last;
  assign o_wrap    = w_col_end;
  assign o_nxt_row = w_nxt_row;
  assign o_nxt_col = w_nxt_col;

endmodule

// File: rtl/conv_result_streamer.sv
// Serializes a captured packed result matrix into one element per beat,
// row-major, over a valid/ready stream, flagging the final element.
module conv_result_streamer
  import conv_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   src_valid,
  input  logic [2:0]             src_m,
  input  logic [2:0]             src_n,
  input  logic [MAT_W-1:0]       src_matrix,
  output logic                   busy,
  output logic                   err,
  output logic                   done,
  output logic [4:0]             beat_count,
  conv_result_streamer_if.master out_if
);

  stream_state_t         r_state;
  stream_state_t         w_state_nxt;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_beat;

  logic [MAT_W-1:0]      r_mat;
  logic [2:0]            r_m;
  logic [2:0]            r_n;
  logic                  r_busy;
  logic                  r_err;
  logic                  r_done;
  logic                  r_out_valid;
  logic [ELEM_WIDTH-1:0] r_out_data;
  logic [4:0]            r_beat_count;

  logic [2:0]            w_lim_m;
  logic [2:0]            w_lim_n;
  logic [2:0]            w_row;
  logic [2:0]            w_col;
  logic                  w_last;
  logic                  w_wrap;
  logic [2:0]            w_nxt_row;
  logic [2:0]            w_nxt_col;
  logic                  w_dims_ok;

  // 25:1 element select from the packed matrix; out-of-range indices give 0.
  function automatic logic [ELEM_WIDTH-1:0] elem_sel(input logic [MAT_W-1:0] mat,
                                                     input logic [2:0]       r,
                                                     input logic [2:0]       c);
    logic [ELEM_WIDTH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_DIM; i++) begin
      for (int unsigned j = 0; j < MAX_DIM; j++) begin
        if ((r == i[2:0]) && (c == j[2:0])) begin
          v = mat[elem_offset(i, j) +: ELEM_WIDTH];
        end
      end
    end
    return v;
  endfunction

  assign w_dims_ok = (src_m != 3'd0) && (src_m <= DIM_MAX_U3) &&
                     (src_n != 3'd0) && (src_n <= DIM_MAX_U3);

  // While idle the counter is loaded from the live source dimensions;
  // afterwards it runs against the captured ones.
  assign w_lim_m = (r_state == ST_IDLE) ? src_m : r_m;
  assign w_lim_n = (r_state == ST_IDLE) ? src_n : r_n;

  rc_index_counter u_idx (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_accept),
    .i_en      (w_beat && !w_last),
    .i_m       (w_lim_m),
    .i_n       (w_lim_n),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_last    (w_last),
    .o_wrap    (w_wrap),
    .o_nxt_row (w_nxt_row),
    .o_nxt_col (w_nxt_col)
  );

  // Next-state and handshake decode; start outside IDLE is ignored silently.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (src_valid && w_dims_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_STREAM;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        w_beat = r_out_valid && out_if.out_ready;
        if (w_beat && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Status outputs registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt == ST_STREAM) || (w_state_nxt == ST_DONE);
      r_err       <= w_reject;
      r_done      <= (w_state_nxt == ST_DONE);
      r_out_valid <= (w_state_nxt == ST_STREAM);
    end
  end

  // Shadow capture, beat counting and element prefetch for the next beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mat        <= '0;
      r_m          <= 3'd0;
      r_n          <= 3'd0;
      r_out_data   <= '0;
      r_beat_count <= 5'd0;
    end else if (w_accept) begin
      r_mat        <= src_matrix;
      r_m          <= src_m;
      r_n          <= src_n;
      r_out_data   <= src_matrix[ELEM_WIDTH-1:0];
      r_beat_count <= 5'd0;
    end else if (w_beat) begin
      r_beat_count <= r_beat_count + 5'd1;
      if (!w_last) begin
        r_out_data <= elem_sel(r_mat, w_nxt_row, w_nxt_col);
      end
    end
  end

  assign busy             = r_busy;
  assign err              = r_err;
  assign done             = r_done;
  assign beat_count       = r_beat_count;
  assign out_if.out_valid = r_out_valid;
  assign out_if.out_data  = r_out_data;
  assign out_if.out_row   = w_row;
  assign out_if.out_col   = w_col;
  assign out_if.out_last  = w_last;

  logic w_unused;
  assign w_unused = w_wrap;

endmodule
